acog_hub_resp: RTL and testbench

Hub-side responder for the cog hub transfer handshake: accepts `hub_read`/`hub_write` requests with a transfer size from `NUM_COGS` cog sequencers, services them one at a time in a rotating slot order against internal hub RAM, and answers each request with a one-cycle acknowledge. It sits between all cog sequencers and the hub memory. For reads it returns zero-extended data on a shared read bus.

---
 rtl/acog_hub_resp_if.sv | 35 +++
 rtl/acog_hub_resp.sv | 155 +++++++++++++++
 tb/tb_acog_hub_resp.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acog_hub_resp_if.sv
// acog_hub_resp_if: cog <-> hub transfer handshake bundle.
//   master modport: cog sequencer side (drives requests, receives ack/data/slot)
//   slave modport : hub responder side
// Signals (cog i occupies slice i of every packed per-cog field):
//   hub_read_in / hub_write_in  per-cog level requests, held until acked
//   hub_tfr_sz_in               per-cog transfer size, 2 bits each
//   hub_addr_in                 per-cog byte address, ADDR_W bits each
//   hub_wdata_in                per-cog right-aligned write data, 32 bits each
//   hub_ack_o                   one-cycle acknowledge, one-hot or zero
//   hub_rdata_o                 shared zero-extended read data
//   hub_slot_o                  current slot index
interface acog_hub_resp_if #(
  parameter int unsigned NUM_COGS = 8,
  parameter int unsigned SLOT_W   = 3,
  parameter int unsigned ADDR_W   = 15
);
  logic [NUM_COGS-1:0]        hub_read_in;
  logic [NUM_COGS-1:0]        hub_write_in;
  logic [2*NUM_COGS-1:0]      hub_tfr_sz_in;
  logic [ADDR_W*NUM_COGS-1:0] hub_addr_in;
  logic [32*NUM_COGS-1:0]     hub_wdata_in;
  logic [NUM_COGS-1:0]        hub_ack_o;
  logic [31:0]                hub_rdata_o;
  logic [SLOT_W-1:0]          hub_slot_o;

  modport master (
    output hub_read_in, hub_write_in, hub_tfr_sz_in, hub_addr_in, hub_wdata_in,
    input  hub_ack_o, hub_rdata_o, hub_slot_o
  );

  modport slave (
    input  hub_read_in, hub_write_in, hub_tfr_sz_in, hub_addr_in, hub_wdata_in,
    output hub_ack_o, hub_rdata_o, hub_slot_o
  );
endinterface

// File: rtl/acog_hub_resp.sv
// acog_hub_resp: hub-side responder. Services one cog request per clock against an
// internal hub RAM of 2^(ADDR_W-2) longs, chosen by a rotating slot counter, and
// answers with a one-cycle ack. Reads return zero-extended lane data on hub_rdata_o.
// Ports:
//   clk_in    clock
//   reset_in  asynchronous active-high reset (RAM contents are kept)
//   bus       acog_hub_resp_if.slave handshake bundle
// Configuration macro HUB_SLOT_SKIP_EN:
//   undefined - strict: only the cog equal to the slot is served, slot +1 every cycle
//   defined   - work-conserving: first eligible cog from the slot upward is served,
//               slot then becomes served cog + 1
// Size encoding: 0 byte, 1 word, 2 long, 3 treated as long.
module acog_hub_resp #(
  parameter int unsigned NUM_COGS = 8,
  parameter int unsigned SLOT_W   = 3,
  parameter int unsigned ADDR_W   = 15
) (
  input logic            clk_in,
  input logic            reset_in,
  acog_hub_resp_if.slave bus
);

  localparam int unsigned MemDepth = 2 ** (ADDR_W - 2);
  localparam logic [1:0]  SzByte   = 2'd0;
  localparam logic [1:0]  SzWord   = 2'd1;

  function automatic logic [SLOT_W-1:0] wrap_add(logic [SLOT_W-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_COGS) s -= NUM_COGS;
    return SLOT_W'(s);
  endfunction

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [NUM_COGS-1:0] ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [NUM_COGS-1:0] eligible;
  logic                serve;
  logic [SLOT_W-1:0]   sel;

  // A cog in its ack cycle is about to drop its request; never serve it twice.
  assign eligible = (bus.hub_read_in | bus.hub_write_in) & ~ack_q;

`ifdef HUB_SLOT_SKIP_EN
  logic [SLOT_W-1:0] cand;

  always_comb begin
    serve = 1'b0;
    sel   = slot_q;
    cand  = slot_q;
    for (int unsigned i = 0; i < NUM_COGS; i++) begin
      cand = wrap_add(slot_q, i);
      if (!serve && eligible[cand]) begin
        serve = 1'b1;
        sel   = cand;
      end
    end
    slot_d = serve ? wrap_add(sel, 1) : wrap_add(slot_q, 1);
  end
`else
  always_comb begin
    sel    = slot_q;
    serve  = eligible[slot_q];
    slot_d = wrap_add(slot_q, 1);
  end
`endif

  // Selected cog's request fields
  int unsigned       sel_i;
  logic              sel_rd;
  logic [1:0]        sel_sz;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  assign sel_i     = 32'(sel);
  assign sel_rd    = bus.hub_read_in[sel];
  assign sel_sz    = bus.hub_tfr_sz_in[2*sel_i +: 2];
  assign sel_addr  = bus.hub_addr_in[ADDR_W*sel_i +: ADDR_W];
  assign sel_wdata = bus.hub_wdata_in[32*sel_i +: 32];

  logic [31:0]       mem [MemDepth];
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       mem_long;
  logic [31:0]       rd_val;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              do_write;

  assign word_idx = sel_addr[ADDR_W-1:2];
  assign mem_long = mem[word_idx];
  // Read wins when both are asserted; the write is discarded, not deferred.
  assign do_write = serve & ~sel_rd & ~reset_in;

  always_comb begin
    rd_val = mem_long;
    case (sel_sz)
      SzByte:  rd_val = {24'b0, mem_long[{sel_addr[1:0], 3'b000} +: 8]};
      SzWord:  rd_val = {16'b0, (sel_addr[1] ? mem_long[31:16] : mem_long[15:0])};
      default: rd_val = mem_long;
    endcase
  end

  // Replicate the right-aligned data across lanes; the byte enables pick the lane.
  always_comb begin
    wr_be   = 4'hF;
    wr_data = sel_wdata;
    case (sel_sz)
      SzByte: begin
        wr_be   = 4'b0001 << sel_addr[1:0];
        wr_data = {4{sel_wdata[7:0]}};
      end
      SzWord: begin
        wr_be   = sel_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{sel_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'hF;
        wr_data = sel_wdata;
      end
    endcase
  end

  // RAM has no reset so contents survive a reset pulse.
  always_ff @(posedge clk_in) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    ack_d = '0;
    if (serve) ack_d[sel] = 1'b1;
    rdata_d = (serve && sel_rd) ? rd_val : rdata_q;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      slot_q  <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      slot_q  <= slot_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.hub_ack_o   = ack_q;
  assign bus.hub_rdata_o = rdata_q;
  assign bus.hub_slot_o  = slot_q;

endmodule

// File: tb/tb_acog_hub_resp.sv
// Directed bench for acog_hub_resp with a byte-addressed reference model.
module tb_acog_hub_resp;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int AW = 15;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;
`ifdef HUB_SLOT_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  bit   started  = 1'b0;
  always #5 clk_in = ~clk_in;

  acog_hub_resp_if #(.NUM_COGS(N), .SLOT_W(SW), .ADDR_W(AW)) bus ();

  acog_hub_resp #(.NUM_COGS(N), .SLOT_W(SW), .ADDR_W(AW)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   mm [0:(1<<AW)-1];
  int           m_slot;
  logic [N-1:0] m_ack;
  logic [31:0]  m_rdata;

  function automatic int nbytes(int c);
    logic [1:0] sz;
    sz = bus.hub_tfr_sz_in[2*c +: 2];
    return (sz == SZ_BYTE) ? 1 : (sz == SZ_WORD) ? 2 : 4;
  endfunction

  function automatic int base_addr(int c);
    int a;
    a = int'(bus.hub_addr_in[AW*c +: AW]);
    return a - (a % nbytes(c));
  endfunction

  function automatic logic [31:0] m_read(int c);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nbytes(c); k++) v = v | (32'(mm[base_addr(c) + k]) << (8 * k));
    return v;
  endfunction

  // Cog served on the coming edge, or -1.
  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_slot + k) % N;
      if ((Skip || k == 0) && (bus.hub_read_in[c] || bus.hub_write_in[c]) && !m_ack[c])
        return c;
    end
    return -1;
  endfunction

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      m_slot  <= 0;
      m_ack   <= '0;
      m_rdata <= '0;
    end else if (m_pick() >= 0) begin
      m_ack <= N'(1) << m_pick();
      if (bus.hub_read_in[m_pick()]) m_rdata <= m_read(m_pick());
      else begin
        for (int k = 0; k < 4; k++)
          if (k < nbytes(m_pick()))
            mm[base_addr(m_pick()) + k] <= bus.hub_wdata_in[32*m_pick() + 8*k +: 8];
      end
      m_slot <= Skip ? (m_pick() + 1) % N : (m_slot + 1) % N;
    end else begin
      m_ack  <= '0;
      m_slot <= (m_slot + 1) % N;
    end
  end

  always @(negedge clk_in) begin
    if (started && !reset_in) begin
      check("cyc_ack", 32'(bus.hub_ack_o), 32'(m_ack));
      check("cyc_rdata", bus.hub_rdata_o, m_rdata);
      check("cyc_slot", 32'(bus.hub_slot_o), 32'(m_slot));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(int c, bit rd, bit wr, logic [1:0] sz, int addr, logic [31:0] wd);
    bus.hub_read_in[c]              = rd;
    bus.hub_write_in[c]             = wr;
    bus.hub_tfr_sz_in[2*c +: 2]     = sz;
    bus.hub_addr_in[AW*c +: AW]     = AW'(addr);
    bus.hub_wdata_in[32*c +: 32]    = wd;
  endtask

  task automatic clr_req(int c);
    bus.hub_read_in[c]  = 1'b0;
    bus.hub_write_in[c] = 1'b0;
  endtask

  // Returns number of negedges from request to visible ack (-1 on timeout).
  task automatic xfer(int c, bit rd, bit wr, logic [1:0] sz, int addr, logic [31:0] wd,
                      output int waited);
    @(negedge clk_in);
    set_req(c, rd, wr, sz, addr, wd);
    waited = -1;
    for (int t = 1; t <= 3 * N; t++) begin
      @(negedge clk_in);
      if (bus.hub_ack_o[c]) begin
        waited = t;
        break;
      end
    end
    clr_req(c);
    if (waited < 0) flag("xfer_timeout");
    @(negedge clk_in);
    check("single_ack", 32'(bus.hub_ack_o[c]), 32'd0);
  endtask

  task automatic wait_slot(int s);
    for (int t = 0; t < 3 * N; t++) begin
      @(negedge clk_in);
      if (int'(bus.hub_slot_o) == s) return;
    end
    flag("wait_slot");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bound expired");
    $fatal(1);
  end

  initial begin
    int w;
    int s;
    int order[$];
    int cnt[N];
    bit twice;
    int first_t, last_t;

    bus.hub_read_in   = '0;
    bus.hub_write_in  = '0;
    bus.hub_tfr_sz_in = '0;
    bus.hub_addr_in   = '0;
    bus.hub_wdata_in  = '0;
    repeat (3) @(negedge clk_in);
    check("reset_ack", 32'(bus.hub_ack_o), 32'd0);
    check("reset_rdata", bus.hub_rdata_o, 32'd0);
    check("reset_slot", 32'(bus.hub_slot_o), 32'd0);
    reset_in = 1'b0;
    started  = 1'b1;

    // long write/read round trip
    xfer(2, 0, 1, SZ_LONG, 'h0100, 32'hDEADBEEF, w);
    xfer(2, 1, 0, SZ_LONG, 'h0100, 32'h0, w);
    check("long_rd", bus.hub_rdata_o, 32'hDEADBEEF);
    check("model_long_rd", m_rdata, 32'hDEADBEEF);

    // byte lane write and lane-selected reads
    xfer(1, 0, 1, SZ_BYTE, 'h0102, 32'h0000005A, w);
    xfer(1, 1, 0, SZ_LONG, 'h0100, 32'h0, w);
    check("long_after_byte", bus.hub_rdata_o, 32'hDE5ABEEF);
    check("model_after_byte", m_rdata, 32'hDE5ABEEF);
    xfer(3, 1, 0, SZ_BYTE, 'h0103, 32'h0, w);
    check("byte_rd_103", bus.hub_rdata_o, 32'h000000DE);
    xfer(3, 1, 0, SZ_WORD, 'h0103, 32'h0, w);
    check("word_rd_103", bus.hub_rdata_o, 32'h0000DE5A);
    xfer(4, 1, 0, SZ_BYTE, 'h0101, 32'h0, w);
    check("byte_rd_101", bus.hub_rdata_o, 32'h000000BE);
    // a write leaves rdata alone
    xfer(4, 0, 1, SZ_WORD, 'h0202, 32'h1234ABCD, w);
    check("rdata_hold_on_write", bus.hub_rdata_o, 32'h000000BE);
    xfer(4, 1, 0, SZ_LONG, 'h0200, 32'h0, w);
    check("model_word_wr", m_rdata[31:16], 32'h0000ABCD);

    // latency: cog 5 asserts while slot is 6
    wait_slot(6);
    set_req(5, 1, 0, SZ_LONG, 'h0100, 32'h0);
    w = -1;
    for (int t = 1; t <= 3 * N; t++) begin
      @(negedge clk_in);
      if (bus.hub_ack_o[5]) begin
        w = t;
        break;
      end
    end
    clr_req(5);
    if (w < 0) flag("latency_timeout");
    else begin
      // strict: sampled on the edge closing the slot=5 cycle, 8 edges away
      check("latency", 32'(w), Skip ? 32'd1 : 32'd8);
      check("latency_slot", 32'(bus.hub_slot_o), 32'd6);
    end

    // all cogs at once
    @(negedge clk_in);
    s = int'(bus.hub_slot_o);
    for (int c = 0; c < N; c++) begin
      set_req(c, 1, 0, SZ_LONG, 'h0100, 32'h0);
      cnt[c] = 0;
    end
    twice   = 1'b0;
    first_t = -1;
    last_t  = -1;
    for (int t = 1; t <= 3 * N; t++) begin
      @(negedge clk_in);
      if ($countones(bus.hub_ack_o) > 1) twice = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (bus.hub_ack_o[c]) begin
          cnt[c]++;
          order.push_back(c);
          if (first_t < 0) first_t = t;
          last_t = t;
          clr_req(c);
        end
      end
    end
    check("all_no_overlap", 32'(twice), 32'd0);
    check("all_count", 32'(order.size()), 32'(N));
    check("all_span", 32'(last_t - first_t), 32'(N - 1));
    for (int c = 0; c < N; c++) check("all_once", 32'(cnt[c]), 32'd1);
    for (int j = 0; j < order.size(); j++) check("all_order", 32'(order[j]), 32'((s + j) % N));

    // read+write together: read wins, RAM untouched
    xfer(0, 0, 1, SZ_LONG, 'h0010, 32'h11223344, w);
    xfer(0, 1, 1, SZ_WORD, 'h0010, 32'h0000AAAA, w);
    check("rw_read_wins", bus.hub_rdata_o, 32'h00003344);
    xfer(0, 1, 0, SZ_LONG, 'h0010, 32'h0, w);
    check("rw_ram_unchanged", bus.hub_rdata_o, 32'h11223344);
    xfer(0, 1, 0, 2'd3, 'h0012, 32'h0, w);
    check("sz3_as_long", bus.hub_rdata_o, 32'h11223344);

`ifndef HUB_SLOT_SKIP_EN
    // request withdrawn before its slot: never acked
    wait_slot(1);
    set_req(3, 1, 0, SZ_LONG, 'h0100, 32'h0);
    @(negedge clk_in);
    clr_req(3);
    w = 0;
    repeat (2 * N) begin
      @(negedge clk_in);
      if (bus.hub_ack_o[3]) w++;
    end
    check("withdrawn_no_ack", 32'(w), 32'd0);
`endif

    // async reset mid-cycle with a pending request
    xfer(6, 0, 1, SZ_LONG, 'h0200, 32'hCAFEF00D, w);
    xfer(6, 1, 0, SZ_LONG, 'h0100, 32'h0, w);
    check("pre_reset_rdata", bus.hub_rdata_o, 32'hDE5ABEEF);
    wait_slot(7);
    set_req(6, 1, 0, SZ_BYTE, 'h0200, 32'h0);
    @(posedge clk_in);
    #2 reset_in = 1'b1;
    #1;
    check("async_rst_ack", 32'(bus.hub_ack_o), 32'd0);
    check("async_rst_rdata", bus.hub_rdata_o, 32'd0);
    check("async_rst_slot", 32'(bus.hub_slot_o), 32'd0);
    clr_req(6);
    @(negedge clk_in);
    reset_in = 1'b0;
    xfer(6, 1, 0, SZ_LONG, 'h0200, 32'h0, w);
    check("ram_kept", bus.hub_rdata_o, 32'hCAFEF00D);
    xfer(7, 1, 0, SZ_BYTE, 'h0200, 32'h0, w);
    check("re_presented", bus.hub_rdata_o, 32'h0000000D);

    repeat (2) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
